// File: rtl/id2exe_fwd.sv
// ID/EXE pipeline register with combinational MEM/WB operand forwarding
// and load-use hazard detection against the instruction held in EXE.
module id2exe_fwd #(
  parameter int WORD_LEN     = 32,
  parameter int EXE_CMD_LEN  = 4,
  parameter int REG_ADDR_LEN = 5,
  parameter int FORWARD_EN   = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    stall,
  input  logic                    flush,
  input  logic                    id_valid,
  input  logic [WORD_LEN-1:0]     id_pc,
  input  logic [WORD_LEN-1:0]     id_reg1,
  input  logic [WORD_LEN-1:0]     id_reg2,
  input  logic [WORD_LEN-1:0]     id_imm,
  input  logic [REG_ADDR_LEN-1:0] id_src1,
  input  logic [REG_ADDR_LEN-1:0] id_src2,
  input  logic [REG_ADDR_LEN-1:0] id_dest,
  input  logic [EXE_CMD_LEN-1:0]  id_exe_cmd,
  input  logic                    id_is_imm,
  input  logic                    id_mem_r_en,
  input  logic                    id_mem_w_en,
  input  logic                    id_wb_en,
  input  logic                    mem_wb_en,
  input  logic [REG_ADDR_LEN-1:0] mem_dest,
  input  logic [WORD_LEN-1:0]     mem_value,
  input  logic                    wb_wb_en,
  input  logic [REG_ADDR_LEN-1:0] wb_dest,
  input  logic [WORD_LEN-1:0]     wb_value,
  output logic [WORD_LEN-1:0]     val1,
  output logic [WORD_LEN-1:0]     val2,
  output logic [EXE_CMD_LEN-1:0]  exe_cmd,
  output logic [WORD_LEN-1:0]     st_value,
  output logic [WORD_LEN-1:0]     exe_pc,
  output logic [REG_ADDR_LEN-1:0] exe_dest,
  output logic                    exe_valid,
  output logic                    exe_mem_r_en,
  output logic                    exe_mem_w_en,
  output logic                    exe_wb_en,
  output logic                    load_use_hazard
);

  localparam bit FWD = (FORWARD_EN != 0);

  typedef struct packed {
    logic                    valid;
    logic [WORD_LEN-1:0]     pc;
    logic [WORD_LEN-1:0]     reg1;
    logic [WORD_LEN-1:0]     reg2;
    logic [WORD_LEN-1:0]     imm;
    logic [REG_ADDR_LEN-1:0] src1;
    logic [REG_ADDR_LEN-1:0] src2;
    logic [REG_ADDR_LEN-1:0] dest;
    logic [EXE_CMD_LEN-1:0]  cmd;
    logic                    is_imm;
    logic                    mem_r_en;
    logic                    mem_w_en;
    logic                    wb_en;
  } stage_t;

  stage_t stage_q, stage_d, bubble;

  always_comb begin
    bubble     = '0;
    bubble.cmd = '1;
  end

  always_comb begin
    stage_d = stage_q;
    if (flush) begin
      stage_d = bubble;
    end else if (!stall) begin
      stage_d.valid    = id_valid;
      stage_d.pc       = id_pc;
      stage_d.reg1     = id_reg1;
      stage_d.reg2     = id_reg2;
      stage_d.imm      = id_imm;
      stage_d.src1     = id_src1;
      stage_d.src2     = id_src2;
      stage_d.dest     = id_dest;
      stage_d.cmd      = id_exe_cmd;
      stage_d.is_imm   = id_is_imm;
      stage_d.mem_r_en = id_mem_r_en;
      stage_d.mem_w_en = id_mem_w_en;
      stage_d.wb_en    = id_wb_en;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) stage_q <= bubble;
    else     stage_q <= stage_d;
  end

  // MEM is the younger producer, so it is checked before WB.
  logic [WORD_LEN-1:0] fwd1, fwd2;
  always_comb begin
    fwd1 = stage_q.reg1;
    if (FWD && stage_q.src1 != '0) begin
      if (mem_wb_en && mem_dest == stage_q.src1)    fwd1 = mem_value;
      else if (wb_wb_en && wb_dest == stage_q.src1) fwd1 = wb_value;
    end
    fwd2 = stage_q.reg2;
    if (FWD && stage_q.src2 != '0) begin
      if (mem_wb_en && mem_dest == stage_q.src2)    fwd2 = mem_value;
      else if (wb_wb_en && wb_dest == stage_q.src2) fwd2 = wb_value;
    end
  end

  // src2 of an immediate op still matters when it is store data.
  always_comb begin
    load_use_hazard = 1'b0;
    if (stage_q.valid && stage_q.mem_r_en && stage_q.dest != '0 && id_valid) begin
      load_use_hazard = (id_src1 == stage_q.dest) ||
                        ((id_src2 == stage_q.dest) && (!id_is_imm || id_mem_w_en));
    end
  end

  assign val1         = fwd1;
  assign val2         = stage_q.is_imm ? stage_q.imm : fwd2;
  assign st_value     = fwd2;
  assign exe_cmd      = stage_q.cmd;
  assign exe_pc       = stage_q.pc;
  assign exe_dest     = stage_q.dest;
  assign exe_valid    = stage_q.valid;
  assign exe_mem_r_en = stage_q.mem_r_en;
  assign exe_mem_w_en = stage_q.mem_w_en;
  assign exe_wb_en    = stage_q.wb_en;

endmodule

// File: tb/tb_id2exe_fwd.sv
// Bench for id2exe_fwd: vector table through a scoreboard queue, then
// hand sequences for reset, stall, flush and load-use behaviour.
module tb_id2exe_fwd;

  logic        clk, rst, stall, flush;
  logic        id_valid, id_is_imm, id_mem_r_en, id_mem_w_en, id_wb_en;
  logic [31:0] id_pc, id_reg1, id_reg2, id_imm;
  logic [4:0]  id_src1, id_src2, id_dest;
  logic [3:0]  id_exe_cmd;
  logic        mem_wb_en, wb_wb_en;
  logic [4:0]  mem_dest, wb_dest;
  logic [31:0] mem_value, wb_value;

  logic [31:0] val1, val2, st_value, exe_pc;
  logic [3:0]  exe_cmd;
  logic [4:0]  exe_dest;
  logic        exe_valid, exe_mem_r_en, exe_mem_w_en, exe_wb_en, load_use_hazard;

  logic [31:0] nf_val1, nf_val2, nf_st_value, nf_exe_pc;
  logic [3:0]  nf_exe_cmd;
  logic [4:0]  nf_exe_dest;
  logic        nf_exe_valid, nf_exe_mem_r_en, nf_exe_mem_w_en, nf_exe_wb_en, nf_hazard;

  id2exe_fwd #(.WORD_LEN(32), .EXE_CMD_LEN(4), .REG_ADDR_LEN(5), .FORWARD_EN(1)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .id_valid(id_valid),
    .id_pc(id_pc), .id_reg1(id_reg1), .id_reg2(id_reg2), .id_imm(id_imm),
    .id_src1(id_src1), .id_src2(id_src2), .id_dest(id_dest), .id_exe_cmd(id_exe_cmd),
    .id_is_imm(id_is_imm), .id_mem_r_en(id_mem_r_en), .id_mem_w_en(id_mem_w_en),
    .id_wb_en(id_wb_en), .mem_wb_en(mem_wb_en), .mem_dest(mem_dest), .mem_value(mem_value),
    .wb_wb_en(wb_wb_en), .wb_dest(wb_dest), .wb_value(wb_value),
    .val1(val1), .val2(val2), .exe_cmd(exe_cmd), .st_value(st_value), .exe_pc(exe_pc),
    .exe_dest(exe_dest), .exe_valid(exe_valid), .exe_mem_r_en(exe_mem_r_en),
    .exe_mem_w_en(exe_mem_w_en), .exe_wb_en(exe_wb_en), .load_use_hazard(load_use_hazard)
  );

  id2exe_fwd #(.WORD_LEN(32), .EXE_CMD_LEN(4), .REG_ADDR_LEN(5), .FORWARD_EN(0)) u_nf (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .id_valid(id_valid),
    .id_pc(id_pc), .id_reg1(id_reg1), .id_reg2(id_reg2), .id_imm(id_imm),
    .id_src1(id_src1), .id_src2(id_src2), .id_dest(id_dest), .id_exe_cmd(id_exe_cmd),
    .id_is_imm(id_is_imm), .id_mem_r_en(id_mem_r_en), .id_mem_w_en(id_mem_w_en),
    .id_wb_en(id_wb_en), .mem_wb_en(mem_wb_en), .mem_dest(mem_dest), .mem_value(mem_value),
    .wb_wb_en(wb_wb_en), .wb_dest(wb_dest), .wb_value(wb_value),
    .val1(nf_val1), .val2(nf_val2), .exe_cmd(nf_exe_cmd), .st_value(nf_st_value),
    .exe_pc(nf_exe_pc), .exe_dest(nf_exe_dest), .exe_valid(nf_exe_valid),
    .exe_mem_r_en(nf_exe_mem_r_en), .exe_mem_w_en(nf_exe_mem_w_en),
    .exe_wb_en(nf_exe_wb_en), .load_use_hazard(nf_hazard)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc, r1, r2, imm;
    logic [4:0]  s1, s2, d;
    logic [3:0]  cmd;
    logic        is_imm, mw;
    logic        mwe; logic [4:0] md; logic [31:0] mv;
    logic        wwe; logic [4:0] wd; logic [31:0] wv;
    logic [31:0] e1, e2, est;
  } vec_t;

  typedef struct {
    logic [31:0] pc, v1, v2, st, n1, n2, nst;
    logic [3:0]  cmd;
    logic [4:0]  dest;
  } exp_t;

  vec_t vec[8];
  exp_t sb[$];
  int unsigned total = 0;
  int unsigned bad   = 0;

  function automatic vec_t mk(
    input logic [31:0] pc, input logic [4:0] s1, input logic [31:0] r1,
    input logic [4:0] s2, input logic [31:0] r2, input logic [31:0] imm,
    input logic is_imm, input logic mw, input logic [4:0] d, input logic [3:0] cmd,
    input logic mwe, input logic [4:0] md, input logic [31:0] mv,
    input logic wwe, input logic [4:0] wd, input logic [31:0] wv,
    input logic [31:0] e1, input logic [31:0] e2, input logic [31:0] est);
    vec_t v;
    v.pc = pc; v.s1 = s1; v.r1 = r1; v.s2 = s2; v.r2 = r2; v.imm = imm;
    v.is_imm = is_imm; v.mw = mw; v.d = d; v.cmd = cmd;
    v.mwe = mwe; v.md = md; v.mv = mv; v.wwe = wwe; v.wd = wd; v.wv = wv;
    v.e1 = e1; v.e2 = e2; v.est = est;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic no_fwd();
    mem_wb_en = 0; mem_dest = 0; mem_value = 0;
    wb_wb_en = 0;  wb_dest = 0;  wb_value = 0;
  endtask

  task automatic drive_id(input logic [31:0] pc, input logic [4:0] s1, input logic [4:0] s2,
                          input logic [4:0] d, input logic [31:0] r1, input logic [31:0] r2,
                          input logic [31:0] imm, input logic [3:0] cmd, input logic is_imm,
                          input logic mr, input logic mw, input logic valid);
    id_pc = pc; id_src1 = s1; id_src2 = s2; id_dest = d; id_reg1 = r1; id_reg2 = r2;
    id_imm = imm; id_exe_cmd = cmd; id_is_imm = is_imm; id_mem_r_en = mr;
    id_mem_w_en = mw; id_valid = valid; id_wb_en = 1'b1;
  endtask

  initial begin
    exp_t e;
    vec[0] = mk(32'h100, 3, 32'h5,  4, 32'h7,  32'h0,  0, 0, 1,  4'h0, 0, 0, 32'h0,  0, 0, 32'h0,  32'h5,  32'h7,  32'h7);
    vec[1] = mk(32'h104, 8, 32'h11, 2, 32'h22, 32'h0,  0, 0, 8,  4'h1, 1, 8, 32'hAA, 1, 8, 32'hBB, 32'hAA, 32'h22, 32'h22);
    vec[2] = mk(32'h108, 8, 32'h11, 2, 32'h22, 32'h0,  0, 0, 8,  4'h1, 0, 8, 32'hAA, 1, 8, 32'hBB, 32'hBB, 32'h22, 32'h22);
    vec[3] = mk(32'h10C, 0, 32'h33, 0, 32'h44, 32'h0,  0, 0, 3,  4'h2, 1, 0, 32'hAA, 1, 0, 32'hBB, 32'h33, 32'h44, 32'h44);
    vec[4] = mk(32'h110, 1, 32'h1,  9, 32'h99, 32'h10, 1, 1, 0,  4'h3, 0, 0, 32'h0,  1, 9, 32'h55, 32'h1,  32'h10, 32'h55);
    vec[5] = mk(32'h114, 4, 32'h4,  5, 32'h3,  32'h20, 0, 0, 2,  4'h4, 1, 5, 32'h77, 1, 4, 32'h66, 32'h66, 32'h77, 32'h77);
    vec[6] = mk(32'h118, 7, 32'h1,  7, 32'h2,  32'h0,  0, 0, 7,  4'h5, 1, 7, 32'hC,  1, 7, 32'hD,  32'hC,  32'hC,  32'hC);
    vec[7] = mk(32'h11C, 10, 32'hA, 11, 32'hB, 32'h30, 1, 0, 10, 4'h6, 0, 10, 32'hE, 0, 11, 32'hF, 32'hA,  32'h30, 32'hB);

    // reset with stall and flush also high, valid instruction presented
    no_fwd();
    rst = 1; stall = 1; flush = 1;
    drive_id(32'hDEAD, 1, 1, 1, 32'h1, 32'h1, 32'h1, 4'h0, 0, 1, 0, 1);
    tick();
    chk("rst_valid", 32'(exe_valid), 32'd0);
    chk("rst_pc", exe_pc, 32'h0);
    chk("rst_cmd", 32'(exe_cmd), 32'hF);
    chk("rst_dest", 32'(exe_dest), 32'd0);
    chk("rst_mr", 32'(exe_mem_r_en), 32'd0);
    chk("rst_val1", val1, 32'h0);
    chk("rst_st", st_value, 32'h0);
    chk("rst_hazard", 32'(load_use_hazard), 32'd0);
    rst = 0; stall = 0; flush = 0;

    // vector table: each entry captured on consecutive edges
    for (int i = 0; i < 8; i++) begin
      no_fwd();
      drive_id(vec[i].pc, vec[i].s1, vec[i].s2, vec[i].d, vec[i].r1, vec[i].r2, vec[i].imm,
               vec[i].cmd, vec[i].is_imm, 1'b0, vec[i].mw, 1'b1);
      e.pc = vec[i].pc; e.v1 = vec[i].e1; e.v2 = vec[i].e2; e.st = vec[i].est;
      e.cmd = vec[i].cmd; e.dest = vec[i].d;
      e.n1 = vec[i].r1; e.n2 = vec[i].is_imm ? vec[i].imm : vec[i].r2; e.nst = vec[i].r2;
      sb.push_back(e);
      tick();
      mem_wb_en = vec[i].mwe; mem_dest = vec[i].md; mem_value = vec[i].mv;
      wb_wb_en = vec[i].wwe;  wb_dest = vec[i].wd;  wb_value = vec[i].wv;
      #1;
      e = sb.pop_front();
      chk($sformatf("v%0d_pc", i), exe_pc, e.pc);
      chk($sformatf("v%0d_cmd", i), 32'(exe_cmd), 32'(e.cmd));
      chk($sformatf("v%0d_dest", i), 32'(exe_dest), 32'(e.dest));
      chk($sformatf("v%0d_valid", i), 32'(exe_valid), 32'd1);
      chk($sformatf("v%0d_val1", i), val1, e.v1);
      chk($sformatf("v%0d_val2", i), val2, e.v2);
      chk($sformatf("v%0d_st", i), st_value, e.st);
      chk($sformatf("v%0d_nf_val1", i), nf_val1, e.n1);
      chk($sformatf("v%0d_nf_val2", i), nf_val2, e.n2);
      chk($sformatf("v%0d_nf_st", i), nf_st_value, e.nst);
      chk($sformatf("v%0d_hazard", i), 32'(load_use_hazard), 32'd0);
    end

    // load-use: lw x6 sits in EXE
    no_fwd();
    drive_id(32'h40, 1, 2, 6, 32'h0, 32'h0, 32'h8, 4'h2, 1, 1, 0, 1);
    tick();
    chk("lw_mr", 32'(exe_mem_r_en), 32'd1);
    chk("lw_dest", 32'(exe_dest), 32'd6);
    drive_id(32'h99, 6, 0, 3, 32'h0, 32'h0, 32'h0, 4'h0, 0, 0, 0, 1); #1;
    chk("lu_src1", 32'(load_use_hazard), 32'd1);
    drive_id(32'h99, 0, 6, 3, 32'h0, 32'h0, 32'h0, 4'h0, 1, 0, 0, 1); #1;
    chk("lu_src2_imm", 32'(load_use_hazard), 32'd0);
    drive_id(32'h99, 0, 6, 3, 32'h0, 32'h0, 32'h0, 4'h0, 1, 0, 1, 1); #1;
    chk("lu_src2_store", 32'(load_use_hazard), 32'd1);
    drive_id(32'h99, 0, 6, 3, 32'h0, 32'h0, 32'h0, 4'h0, 0, 0, 0, 1); #1;
    chk("lu_src2_reg", 32'(load_use_hazard), 32'd1);
    drive_id(32'h99, 6, 6, 3, 32'h0, 32'h0, 32'h0, 4'h0, 0, 0, 0, 0); #1;
    chk("lu_id_invalid", 32'(load_use_hazard), 32'd0);
    drive_id(32'h99, 6, 0, 3, 32'h0, 32'h0, 32'h0, 4'h7, 0, 0, 0, 1);
    stall = 1;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk($sformatf("stall%0d_pc", i), exe_pc, 32'h40);
      chk($sformatf("stall%0d_mr", i), 32'(exe_mem_r_en), 32'd1);
      chk($sformatf("stall%0d_cmd", i), 32'(exe_cmd), 32'h2);
      chk($sformatf("stall%0d_hazard", i), 32'(load_use_hazard), 32'd1);
    end
    stall = 0; flush = 1;
    tick();
    chk("flush_mr", 32'(exe_mem_r_en), 32'd0);
    chk("flush_cmd", 32'(exe_cmd), 32'hF);
    chk("flush_valid", 32'(exe_valid), 32'd0);
    chk("flush_pc", exe_pc, 32'h0);
    chk("flush_hazard", 32'(load_use_hazard), 32'd0);

    // flush together with stall
    flush = 0;
    drive_id(32'h200, 1, 2, 4, 32'h5, 32'h6, 32'h0, 4'h3, 0, 0, 0, 1);
    tick();
    chk("cap200_pc", exe_pc, 32'h200);
    stall = 1; flush = 1;
    tick();
    chk("fs_valid", 32'(exe_valid), 32'd0);
    chk("fs_cmd", 32'(exe_cmd), 32'hF);
    chk("fs_pc", exe_pc, 32'h0);

    // reset mid-stall, then first capture right after release
    stall = 0; flush = 0;
    drive_id(32'h300, 1, 2, 4, 32'h5, 32'h6, 32'h0, 4'h3, 0, 0, 0, 1);
    tick();
    stall = 1;
    drive_id(32'h304, 1, 2, 5, 32'h5, 32'h6, 32'h0, 4'h4, 0, 0, 0, 1);
    tick();
    chk("rs_held_pc", exe_pc, 32'h300);
    rst = 1;
    tick();
    chk("rs_pc", exe_pc, 32'h0);
    chk("rs_valid", 32'(exe_valid), 32'd0);
    rst = 0; stall = 0;
    tick();
    chk("rs_first_cap", exe_pc, 32'h304);

    // back-to-back captures through the scoreboard
    for (int i = 0; i < 3; i++) begin
      drive_id(32'h400 + 32'(4 * i), 1, 2, 5'(i + 1), 32'h0, 32'h0, 32'h0, 4'(i), 0, 0, 0, 1);
      e.pc = 32'h400 + 32'(4 * i); e.dest = 5'(i + 1); e.cmd = 4'(i);
      e.v1 = 0; e.v2 = 0; e.st = 0; e.n1 = 0; e.n2 = 0; e.nst = 0;
      sb.push_back(e);
      tick();
      e = sb.pop_front();
      chk($sformatf("b2b%0d_pc", i), exe_pc, e.pc);
      chk($sformatf("b2b%0d_dest", i), 32'(exe_dest), 32'(e.dest));
      chk($sformatf("b2b%0d_cmd", i), 32'(exe_cmd), 32'(e.cmd));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
